tm_spi_mem_master: RTL and testbench

Parametrised SPI memory master for the Turing-machine core. It turns single-word read/write requests into SPI RAM transactions: command byte, address bytes, optional dummy bits, then data. It generalises the fixed state-store and tape-store SPI links: address width, data width, SCK divider, command opcodes and dummy cycles are all parameters. One instance serves each external memory (state table, tape). Active-high spi_cs is inverted at the pad level.

---
 rtl/tm_spi_mem_master.sv | 148 ++++++++++++++
 tb/tb_tm_spi_mem_master.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/tm_spi_mem_master.sv
// SPI RAM master: one read or write word per request.
// Frame on the wire: opcode, address bytes, dummy bits (reads only), data word.
// SPI mode 0. The SCK half-period is CLK_DIV clk cycles; MISO is sampled as SCK rises.
module tm_spi_mem_master #(
    parameter int          ADDR_W     = 16,
    parameter int          DATA_W     = 8,
    parameter int          CLK_DIV    = 1,
    parameter logic [7:0]  CMD_READ   = 8'h03,
    parameter logic [7:0]  CMD_WRITE  = 8'h02,
    parameter int          DUMMY_BITS = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              spi_cs,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int ADDR_BYTES = (ADDR_W + 7) / 8;
    localparam int ABITS      = 8 * ADDR_BYTES;
    localparam int NB_WR      = 8 + ABITS + DATA_W;
    localparam int NB_RD      = NB_WR + DUMMY_BITS;
    localparam int MAXB       = NB_RD;
    localparam int PAD        = MAXB - 8 - ABITS;
    localparam int BC_W       = $clog2(MAXB + 1);
    localparam int DIV_W      = $clog2(CLK_DIV + 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_DONE} state_t;

    state_t            state, state_nx;
    logic [DIV_W-1:0]  div_cnt;
    logic              sck_ph;      // 0 = low half of the bit period, 1 = high half
    logic [BC_W-1:0]   bit_cnt;
    logic              wr_q;
    logic [MAXB-1:0]   tx_sr;       // outgoing frame, MSB is on the wire
    logic [MAXB-1:0]   tx_load;
    logic [DATA_W-1:0] rx_sr;       // the last DATA_W samples are the data word
    logic              div_last;
    logic              bit_last;
    logic              hs;

    assign div_last  = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign bit_last  = (bit_cnt == (wr_q ? BC_W'(NB_WR - 1) : BC_W'(NB_RD - 1)));
    assign req_ready = (state == S_IDLE) && !rst;
    assign hs        = req_valid && req_ready;

    // Frame image: the dummy bits and the read data slot are left as zeros.
    always_comb begin
        tx_load = {(req_write ? CMD_WRITE : CMD_READ), ABITS'(req_addr), {PAD{1'b0}}};
        if (req_write)
            tx_load = tx_load | (MAXB'(req_wdata) << DUMMY_BITS);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic and SPI pin decode
    always_comb begin
        state_nx  = state;
        spi_cs    = 1'b0;
        spi_sck   = 1'b0;
        spi_mosi  = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (hs) state_nx = S_SETUP;
            end
            S_SETUP: begin
                spi_cs   = 1'b1;
                spi_mosi = tx_sr[MAXB-1];
                if (div_last) state_nx = S_SHIFT;
            end
            S_SHIFT: begin
                spi_cs   = 1'b1;
                spi_sck  = sck_ph;
                spi_mosi = tx_sr[MAXB-1];
                if (div_last && sck_ph && bit_last) state_nx = S_HOLD;
            end
            S_HOLD: begin
                spi_cs = 1'b1;
                if (div_last) state_nx = S_DONE;
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                state_nx  = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath: divider, bit counter, shift registers, read data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            sck_ph    <= 1'b0;
            bit_cnt   <= '0;
            wr_q      <= 1'b0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            rsp_rdata <= '0;
        end else begin
            div_cnt <= (state == S_IDLE || state == S_DONE || div_last) ? '0 : div_cnt + DIV_W'(1);
            case (state)
                S_IDLE: begin
                    if (hs) begin
                        wr_q    <= req_write;
                        tx_sr   <= tx_load;
                        bit_cnt <= '0;
                        sck_ph  <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (div_last) begin
                        if (!sck_ph) begin
                            // SCK rises on this edge: sample MISO
                            sck_ph <= 1'b1;
                            rx_sr  <= {rx_sr[DATA_W-2:0], spi_miso};
                        end else begin
                            // SCK falls: advance MOSI to the next bit
                            sck_ph  <= 1'b0;
                            bit_cnt <= bit_cnt + BC_W'(1);
                            tx_sr   <= {tx_sr[MAXB-2:0], 1'b0};
                        end
                    end
                end
                S_HOLD: begin
                    if (div_last && !wr_q) rsp_rdata <= rx_sr;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tm_spi_mem_master.sv
// Bench for tm_spi_mem_master: u0 uses the default parameters,
// u1 uses ADDR_W=24, DATA_W=16, DUMMY_BITS=8, CLK_DIV=3.
module tb_tm_spi_mem_master;

    int tests = 0;
    int fails = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic v0, w0, mi0, v1, w1, mi1;
    logic [15:0] a0;
    logic [7:0]  d0;
    logic [23:0] a1;
    logic [15:0] d1;
    logic rr0, rv0, bz0, cs0, sk0, mo0;
    logic rr1, rv1, bz1, cs1, sk1, mo1;
    logic [7:0]  rd0;
    logic [15:0] rd1;
    logic [15:0] exp_rd [2];

    tm_spi_mem_master u0 (
        .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rr0), .req_write(w0),
        .req_addr(a0), .req_wdata(d0), .rsp_valid(rv0), .rsp_rdata(rd0), .busy(bz0),
        .spi_cs(cs0), .spi_sck(sk0), .spi_mosi(mo0), .spi_miso(mi0));

    tm_spi_mem_master #(.ADDR_W(24), .DATA_W(16), .CLK_DIV(3), .DUMMY_BITS(8)) u1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rr1), .req_write(w1),
        .req_addr(a1), .req_wdata(d1), .rsp_valid(rv1), .rsp_rdata(rd1), .busy(bz1),
        .spi_cs(cs1), .spi_sck(sk1), .spi_mosi(mo1), .spi_miso(mi1));

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int b, input logic v, input logic w, input logic [23:0] addr,
                         input logic [15:0] wdata);
        if (b == 0) begin v0 = v; w0 = w; a0 = addr[15:0]; d0 = wdata[7:0]; end
        else        begin v1 = v; w1 = w; a1 = addr;       d1 = wdata;      end
    endtask

    task automatic set_miso(input int b, input logic m);
        if (b == 0) mi0 = m; else mi1 = m;
    endtask

    task automatic observe(input int b, output logic o_cs, output logic o_sck, output logic o_mosi,
                           output logic o_rv, output logic o_rr, output logic o_bz,
                           output logic [15:0] o_rd);
        if (b == 0) begin
            o_cs = cs0; o_sck = sk0; o_mosi = mo0; o_rv = rv0; o_rr = rr0; o_bz = bz0; o_rd = {8'h00, rd0};
        end else begin
            o_cs = cs1; o_sck = sk1; o_mosi = mo1; o_rv = rv1; o_rr = rr1; o_bz = bz1; o_rd = rd1;
        end
    endtask

    function automatic logic [127:0] pack(input bit q[$]);
        logic [127:0] v = '0;
        foreach (q[i]) v = {v[126:0], q[i]};
        return v;
    endfunction

    // One transaction on instance b. rst_at >= 0 asserts reset during that bit index.
    // keep leaves req_valid high afterwards so the next call is back-to-back.
    task automatic run(input string nm, input int b, input bit wr, input logic [23:0] addr,
                       input logic [15:0] wdata, input logic [15:0] rdat, input int rst_at,
                       input bit keep);
        int D, AB, DW, DUM, N, LAT;
        bit exp_q[$], got_q[$], mq[$];
        logic [7:0] cmd;
        logic c, s, m, rv, rr, bz;
        logic [15:0] rd, old_rd;
        int first_cs, last_cs, cs_cnt, rsp_cyc, rv_cnt, rises, first_rise, prev_rise, hrun;
        int per_viol, mviol, viol, hold_viol;
        logic ps, pm;

        D = b ? 3 : 1; AB = b ? 3 : 2; DW = b ? 16 : 8; DUM = b ? 8 : 0;
        N = 8 + 8 * AB + (wr ? 0 : DUM) + DW;
        LAT = D * (2 * N + 2);
        cmd = wr ? 8'h02 : 8'h03;
        for (int i = 7; i >= 0; i--) exp_q.push_back(cmd[i]);
        for (int i = 8 * AB - 1; i >= 0; i--) exp_q.push_back(addr[i]);
        if (!wr) for (int i = 0; i < DUM; i++) exp_q.push_back(1'b0);
        for (int i = DW - 1; i >= 0; i--) exp_q.push_back(wr ? wdata[i] : 1'b0);
        // Slave drives random noise before the data slot, then the word MSB first
        for (int i = 0; i < N - DW; i++) mq.push_back(1'($urandom));
        for (int i = DW - 1; i >= 0; i--) mq.push_back(rdat[i]);

        old_rd = exp_rd[b];
        if (!wr) exp_rd[b] = b ? rdat : {8'h00, rdat[7:0]};

        @(posedge clk); #1;
        drive(b, 1'b1, wr, addr, wdata);
        set_miso(b, mq[0]);
        observe(b, c, s, m, rv, rr, bz, rd);
        chk({nm, "_ready_idle"}, rr, 1);
        @(posedge clk); #1;
        // Inputs are latched at the handshake; scramble them now
        drive(b, keep, 1'($urandom), 24'($urandom), 16'($urandom));

        first_cs = -1; last_cs = -1; cs_cnt = 0; rsp_cyc = -1; rv_cnt = 0; rises = 0;
        first_rise = -1; prev_rise = -1; hrun = 0; per_viol = 0; mviol = 0; viol = 0; hold_viol = 0;
        ps = 1'b0; pm = 1'b0;
        for (int k = 1; k <= LAT + 4; k++) begin
            observe(b, c, s, m, rv, rr, bz, rd);
            if (c) begin
                cs_cnt++;
                if (first_cs < 0) first_cs = k;
                last_cs = k;
            end
            if (rsp_cyc < 0 && (!bz || rr)) viol++;
            if (s && !c) viol++;
            if (!c && m) mviol++;
            if (k > 1 && m !== pm && !(ps && !s)) mviol++;
            if (s && !ps) begin
                if (rises < 128) got_q.push_back(m);
                rises++;
                if (first_rise < 0) first_rise = k;
                else if (k - prev_rise != 2 * D) per_viol++;
                prev_rise = k;
            end
            if (s) hrun++;
            else if (ps) begin
                if (hrun != D) per_viol++;
                hrun = 0;
            end
            if (rsp_cyc < 0 && !rv && rd !== old_rd) hold_viol++;
            set_miso(b, (rises < N) ? mq[rises] : 1'b0);
            if (rv) begin
                rv_cnt++;
                if (rsp_cyc < 0) begin
                    rsp_cyc = k;
                    chk({nm, "_rdata"}, rd, exp_rd[b]);
                end
            end
            ps = s; pm = m;
            if (rst_at >= 0 && rises == rst_at + 1) begin
                rst = 1'b1;
                observe(b, c, s, m, rv, rr, bz, rd);
                chk({nm, "_ready_in_rst"}, rr, 0);
                @(posedge clk); #1;
                rst = 1'b0;
                exp_rd[0] = '0; exp_rd[1] = '0;
                observe(b, c, s, m, rv, rr, bz, rd);
                chk({nm, "_rst_pins"}, {c, s, m, rv}, 4'b0000);
                chk({nm, "_rst_rdata"}, rd, 0);
                rv_cnt = 0;
                for (int j = 0; j < 2 * LAT; j++) begin
                    @(posedge clk); #1;
                    observe(b, c, s, m, rv, rr, bz, rd);
                    if (rv || c) rv_cnt++;
                end
                chk({nm, "_rst_no_rsp"}, rv_cnt, 0);
                return;
            end
            if (rsp_cyc > 0 && k >= rsp_cyc + (keep ? 0 : 1)) break;
            @(posedge clk); #1;
        end

        chk({nm, "_cs_first"}, first_cs, 1);
        chk({nm, "_cs_last"}, last_cs, LAT);
        chk({nm, "_cs_count"}, cs_cnt, LAT);
        chk({nm, "_rsp_cycle"}, rsp_cyc, LAT + 1);
        chk({nm, "_rsp_pulses"}, rv_cnt, 1);
        chk({nm, "_sck_rises"}, rises, N);
        chk({nm, "_mosi_stream"}, pack(got_q), pack(exp_q));
        chk({nm, "_first_rise"}, first_rise, 2 * D + 1);
        chk({nm, "_sck_timing"}, per_viol, 0);
        chk({nm, "_mosi_stable"}, mviol, 0);
        chk({nm, "_ready_busy"}, viol, 0);
        chk({nm, "_rdata_hold"}, hold_viol, 0);
    endtask

    initial begin
        logic c, s, m, rv, rr, bz;
        logic [15:0] rd;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        mi0 = 1'b0; mi1 = 1'b0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        observe(0, c, s, m, rv, rr, bz, rd);
        chk("reset_ready_low", rr, 0);
        chk("reset_pins0", {c, s, m, rv, bz}, 5'b00000);
        chk("reset_rdata0", rd, 0);
        observe(1, c, s, m, rv, rr, bz, rd);
        chk("reset_pins1", {c, s, m, rv, bz}, 5'b00000);
        chk("reset_rdata1", rd, 0);
        rst = 1'b0;
        #1;
        observe(0, c, s, m, rv, rr, bz, rd);
        chk("ready_after_reset", rr, 1);

        run("wr1234", 0, 1'b1, 24'h1234, 16'h00A5, 16'h005A, -1, 1'b0);
        run("rd00ff", 0, 1'b0, 24'h00FF, 16'h0000, 16'h003C, -1, 1'b0);
        run("wide_rd", 1, 1'b0, 24'hABCDEF, 16'h0000, 16'hBEEF, -1, 1'b0);
        run("wide_wr", 1, 1'b1, 24'hABCDEF, 16'h1357, 16'h2468, -1, 1'b0);
        run("b2b_a", 0, 1'b1, 24'h0042, 16'h0011, 16'h0000, -1, 1'b1);
        run("b2b_b", 0, 1'b0, 24'h4321, 16'h0000, 16'h00C3, -1, 1'b0);
        run("rst_mid", 0, 1'b0, 24'h5555, 16'h0000, 16'h0077, 10, 1'b0);
        run("after_rst", 0, 1'b0, 24'h0AAA, 16'h0000, 16'h0099, -1, 1'b0);
        for (int i = 0; i < 4; i++)
            run("rand0", 0, 1'($urandom), 24'($urandom), 16'($urandom), 16'($urandom), -1, 1'b0);
        for (int i = 0; i < 2; i++)
            run("rand1", 1, 1'($urandom), 24'($urandom), 16'($urandom), 16'($urandom), -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
